// File: rtl/ddr_read_arbiter.sv
// Round-robin arbiter sharing one DDR read port among NUM_REQ requesters.
// An in-order ID FIFO steers each returning beat back to the requester that issued it.
module ddr_read_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [NUM_REQ-1:0]          resp_valid_o,
  output logic [DATA_W-1:0]           resp_data_o,
  output logic [ADDR_W-1:0]           ddr_address_o,
  output logic                        ddr_r_en_o,
  input  logic [DATA_W-1:0]           ddr_r_data_i,
  input  logic                        ddr_r_valid_i,
  output logic                        err_o
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ID_W-1:0]   fifo_q [MAX_OUTSTANDING];
  logic [ADDR_W-1:0] ddr_address_q, ddr_address_d;
  logic              ddr_r_en_q;
  logic              err_q;

  logic              found;
  logic [ID_W-1:0]   win_id;
  logic [ADDR_W-1:0] win_addr;
  logic              credit_ok;
  logic              grant;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Search from rr_ptr_q upward (mod NUM_REQ) for the first valid requester.
  always_comb begin
    int idx;
    found    = 1'b0;
    win_id   = '0;
    win_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found    = 1'b1;
        win_id   = ID_W'(idx);
        win_addr = req_addr_i[idx*ADDR_W +: ADDR_W];
      end
    end
  end

  // A pop this cycle does not return its credit until the next cycle.
  assign credit_ok = (count_q < CNT_W'(MAX_OUTSTANDING));
  assign grant     = found && credit_ok && !rst_i;
  assign pop       = ddr_r_valid_i && (count_q != '0) && !rst_i;

  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[win_id] = 1'b1;
    resp_valid_o = '0;
    if (pop) resp_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
  end

  assign resp_data_o = ddr_r_data_i;

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    ddr_address_d = ddr_address_q;
    count_d       = count_q;
    if (grant) begin
      rr_ptr_d      = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      ddr_address_d = win_addr;
    end
    unique case ({grant, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q      <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ddr_address_q <= '0;
      ddr_r_en_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      count_q       <= count_d;
      ddr_address_q <= ddr_address_d;
      ddr_r_en_q    <= grant;
      if (grant) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (ddr_r_valid_i && (count_q == '0)) err_q <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (grant) fifo_q[wr_ptr_q] <= win_id;
  end

  assign ddr_address_o = ddr_address_q;
  assign ddr_r_en_o    = ddr_r_en_q;
  assign err_o         = err_q;

endmodule
